// File: rtl/alu_srcb_pipe.sv
// ============================================================================
// Module   : alu_srcb_pipe
// Function : ALU source-B operand select + immediate extension, registered
//            behind a valid/ready stage with a one-entry skid buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_srcb_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 6,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]        sel,
  input  logic [1:0]              ext_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_sticky,
  input  logic                    err_clr
);

  localparam logic [SEL_W:0] c_num_in = NUM_IN[SEL_W:0];

  generate
    if (WIDTH < 16) begin : g_bad_width
      $error("alu_srcb_pipe: WIDTH must be >= 16");
    end
    if (NUM_IN < 2 || NUM_IN > (1 << SEL_W)) begin : g_bad_num_in
      $error("alu_srcb_pipe: NUM_IN must be in 2..2**SEL_W");
    end
  endgenerate

  logic [WIDTH-1:0] w_pick;
  logic [WIDTH-1:0] w_sx;
  logic [WIDTH-1:0] w_result;
  logic             w_sel_err;
  logic             w_take;
  logic             w_pop;
  logic             w_main_free;

  logic [WIDTH-1:0] r_main_data;
  logic             r_main_valid;
  logic             r_main_err;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_valid;
  logic             r_skid_err;
  logic             r_err_sticky;
  logic             r_ready_en;

  assign w_sel_err = ({1'b0, sel} >= c_num_in);

  always_comb begin
    w_pick = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_pick = in_flat[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_sx = {{(WIDTH-16){w_pick[15]}}, w_pick[15:0]};

  always_comb begin
    w_result = '0;
    if (!w_sel_err) begin
      case (ext_mode)
        2'd0:    w_result = w_pick;
        2'd1:    w_result = w_sx;
        2'd2:    w_result = {{(WIDTH-16){1'b0}}, w_pick[15:0]};
        default: w_result = {w_sx[WIDTH-3:0], 2'b00};
      endcase
    end
  end

  // r_ready_en keeps in_ready low until the first edge after reset release
  assign in_ready    = r_ready_en & ~r_skid_valid;
  assign w_take      = in_valid & in_ready & ~flush;
  assign w_pop       = r_main_valid & out_ready;
  assign w_main_free = ~r_main_valid | w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data  <= '0;
      r_main_valid <= 1'b0;
      r_main_err   <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_err   <= 1'b0;
      r_ready_en   <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (flush) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_main_free) begin
        if (r_skid_valid) begin
          r_main_data  <= r_skid_data;
          r_main_err   <= r_skid_err;
          r_main_valid <= 1'b1;
          r_skid_valid <= 1'b0;
        end else if (w_take) begin
          r_main_data  <= w_result;
          r_main_err   <= w_sel_err;
          r_main_valid <= 1'b1;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_take) begin
        r_skid_data  <= w_result;
        r_skid_err   <= w_sel_err;
        r_skid_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
    end else if (w_take && w_sel_err) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign out_data    = r_main_data;
  assign out_valid   = r_main_valid;
  assign out_sel_err = r_main_err;
  assign err_sticky  = r_err_sticky;

endmodule

`default_nettype wire

// File: tb/tb_alu_srcb_pipe.sv
// ============================================================================
// Module   : tb_alu_srcb_pipe
// Function : Directed + randomized checks of alu_srcb_pipe against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_srcb_pipe;

  localparam int W = 32;
  localparam int N = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] in_flat;
  logic [2:0]     sel;
  logic [1:0]     ext_mode;
  logic           in_valid;
  logic           in_ready;
  logic           flush;
  logic [W-1:0]   out_data;
  logic           out_sel_err;
  logic           out_valid;
  logic           out_ready;
  logic           err_sticky;
  logic           err_clr;

  always #5 clk = ~clk;

  alu_srcb_pipe #(.WIDTH(W), .NUM_IN(N), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_flat(in_flat), .sel(sel), .ext_mode(ext_mode),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .out_data(out_data),
    .out_sel_err(out_sel_err), .out_valid(out_valid), .out_ready(out_ready),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected operand from plain integer arithmetic.
  function automatic logic [31:0] expect_val(input logic [N*W-1:0] flat, input int s, input int m);
    logic [31:0] v;
    int x;
    if (s >= N) return 32'd0;
    v = flat[s*W +: W];
    x = int'(v[15:0]);
    if (x >= 32768) x = x - 65536;
    case (m)
      0:       return v;
      1:       return 32'(x);
      2:       return v % 32'h10000;
      default: return 32'(x * 4);
    endcase
  endfunction

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } beat_t;

  beat_t       q[$];
  logic        m_sticky;
  logic        m_ready_en;
  logic [31:0] last_out;

  // Model: up to two held beats in FIFO order; ready while fewer than two held.
  always @(posedge clk or negedge rst_n) begin
    beat_t b;
    bit    acc;
    if (!rst_n) begin
      q.delete();
      m_sticky   = 1'b0;
      m_ready_en = 1'b0;
      last_out   = 32'd0;
    end else begin
      acc = in_valid && m_ready_en && (q.size() < 2) && !flush;
      b.d = expect_val(in_flat, int'(sel), int'(ext_mode));
      b.e = (int'(sel) >= N);
      if (acc && b.e) m_sticky = 1'b1;
      else if (err_clr) m_sticky = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
      if (q.size() > 0) last_out = q[0].d;
      m_ready_en = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (m_ready_en && q.size() < 2)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
      chk("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
      chk("out_data", out_data, last_out);
      if (q.size() > 0) chk("out_sel_err", {31'd0, out_sel_err}, {31'd0, q[0].e});
    end
  end

  initial begin
    logic [31:0] mode_exp [3];
    mode_exp[0] = 32'hFFFF_8004;
    mode_exp[1] = 32'h0000_8004;
    mode_exp[2] = 32'hFFFE_0010;
    in_flat = '0; sel = '0; ext_mode = '0; in_valid = 1'b0;
    flush = 1'b0; out_ready = 1'b0; err_clr = 1'b0;

    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_sel_err", {31'd0, out_sel_err}, 32'd0);
    chk("rst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Walk all legal selects with pass-through.
    for (int k = 0; k < N; k++) in_flat[k*W +: W] = 32'h1000_0000 + k;
    out_ready = 1'b1; in_valid = 1'b1; ext_mode = 2'd0;
    for (int k = 0; k < N; k++) begin
      sel = 3'(k);
      @(negedge clk);
      chk("walk_data", out_data, 32'h1000_0000 + k);
      chk("walk_valid", {31'd0, out_valid}, 32'd1);
    end

    // Extension modes.
    in_flat[2*W +: W] = 32'h0000_8004; sel = 3'd2;
    for (int m = 1; m <= 3; m++) begin
      ext_mode = 2'(m);
      @(negedge clk);
      chk("ext_mode", out_data, mode_exp[m-1]);
    end

    // Illegal selects and sticky error.
    for (int s = 6; s <= 7; s++) begin
      sel = 3'(s); ext_mode = 2'd1;
      @(negedge clk);
      chk("bad_sel_data", out_data, 32'd0);
      chk("bad_sel_err", {31'd0, out_sel_err}, 32'd1);
      chk("bad_sel_sticky", {31'd0, err_sticky}, 32'd1);
    end
    in_valid = 1'b0; err_clr = 1'b1;
    @(negedge clk);
    chk("err_clr", {31'd0, err_sticky}, 32'd0);
    in_valid = 1'b1; sel = 3'd7;
    @(negedge clk);
    chk("clr_vs_set", {31'd0, err_sticky}, 32'd1);
    err_clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    // Backpressure A,B,C.
    out_ready = 1'b0; sel = 3'd0; ext_mode = 2'd0; in_valid = 1'b1;
    in_flat[0 +: W] = 32'hAAAA_0001;
    @(negedge clk);
    in_flat[0 +: W] = 32'hBBBB_0002;
    @(negedge clk);
    chk("bp_skid_full", {31'd0, in_ready}, 32'd0);
    in_flat[0 +: W] = 32'hCCCC_0003;
    @(negedge clk);
    chk("bp_hold_A", out_data, 32'hAAAA_0001);
    chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_B", out_data, 32'hBBBB_0002);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_C", out_data, 32'hCCCC_0003);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_hold_last", out_data, 32'hCCCC_0003);

    // Flush with both stages full, then with only main full and a live accept.
    out_ready = 1'b0; in_valid = 1'b1;
    in_flat[0 +: W] = 32'hEEEE_0001;
    @(negedge clk);
    in_flat[0 +: W] = 32'hEEEE_0002;
    @(negedge clk);
    in_flat[0 +: W] = 32'hEEEE_0003; flush = 1'b1;
    @(negedge clk);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b0; in_flat[0 +: W] = 32'hEEEE_0004;
    @(negedge clk);
    in_flat[0 +: W] = 32'hEEEE_0005; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    // Asynchronous reset mid-stream with skid full.
    out_ready = 1'b0; in_valid = 1'b1;
    in_flat[0 +: W] = 32'h1111_0001;
    @(negedge clk);
    in_flat[0 +: W] = 32'h1111_0002;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data", out_data, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_flat[0 +: W] = 32'h2222_0001; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("post_rst_data", out_data, 32'h2222_0001);
    in_valid = 1'b0;
    @(negedge clk);

    // Randomized traffic; the negedge checker compares against the model.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) in_flat[k*W +: W] = $urandom;
      sel       = 3'($urandom_range(0, 7));
      ext_mode  = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      err_clr   = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
